fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that sits directly upstream of the team's simple dual-port `memory` block and drives both of its ports.
- Accepts a valid/ready write stream and converts it into memory writes.
- Prefetches words through the memory's registered read port and presents them as a valid/ready read stream.
- Storage lives in the external memory instance; this block owns pointers, occupancy, flow control and read-latency handling.

---
 rtl/fifo_ctrl.sv | 157 +++++++++++++++
 tb/tb_fifo_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
//
// Synchronous FIFO controller for an external simple dual-port memory with a
// registered read port. This block owns the write/read pointers, the count of
// words sitting in memory, flow control, and the one-cycle read latency. The
// memory's read register doubles as the output stage. Total capacity is
// therefore DEPTH words in memory plus one in the output stage.
//
// Ports:
//   clk, rst_n              - single clock, asynchronous active-low reset
//   s_valid/s_ready/s_data  - write stream (valid/ready)
//   m_valid/m_ready/m_data  - read stream (valid/ready), m_data = mem_rd_data
//   mem_wr_en/addr/data     - memory write port
//   mem_rd_en/addr          - memory read port request
//   mem_rd_data             - memory registered read data (holds when !rd_en)
//   count                   - words held (memory plus output stage)
//
// Optional build macro FIFO_CTRL_ALMOST_FLAGS_EN adds parameters AF_LEVEL and
// AE_LEVEL and the registered outputs almost_full / almost_empty.
// -----------------------------------------------------------------------------
module fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDRSIZE   = $clog2(DEPTH),
    parameter int CNTSIZE    = $clog2(DEPTH + 2)
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    ,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  mem_wr_en,
    output logic [ADDRSIZE-1:0]   mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_en,
    output logic [ADDRSIZE-1:0]   mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [CNTSIZE-1:0]    count
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    localparam logic [ADDRSIZE-1:0] LAST_ADDR = ADDRSIZE'(DEPTH - 1);
    localparam logic [CNTSIZE-1:0]  FULL_CNT  = CNTSIZE'(DEPTH);

    logic [ADDRSIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRSIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTSIZE-1:0]  mem_cnt_q, mem_cnt_d;
    logic                m_valid_q, m_valid_d;
    logic                push, fetch, pop;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can
        // leave it unassigned and infer a latch.
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_cnt_d = mem_cnt_q;
        m_valid_d = m_valid_q;

        // Readiness depends only on registered state (and reset), never on
        // m_ready, so a slot freed by a fetch while full opens next cycle.
        s_ready = rst_n && (mem_cnt_q != FULL_CNT);
        push    = s_valid && s_ready;
        pop     = m_valid_q && m_ready;
        // Refill the output register whenever it is empty or being drained.
        // mem_cnt_q is pre-edge, so a fetch never hits this cycle's write slot.
        fetch   = (mem_cnt_q != '0) && (!m_valid_q || m_ready);

        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (fetch) begin
            rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({push, fetch})
            2'b10:   mem_cnt_d = mem_cnt_q + 1'b1;
            2'b01:   mem_cnt_d = mem_cnt_q - 1'b1;
            default: mem_cnt_d = mem_cnt_q;
        endcase

        if (fetch) begin
            m_valid_d = 1'b1;
        end else if (pop) begin
            m_valid_d = 1'b0;
        end
    end

    // NOTE: only control state is reset; the words live in the external
    // memory and are never cleared, since m_valid gates any stale read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mem_cnt_q <= '0;
            m_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge
            // values regardless of statement order.
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_cnt_q <= mem_cnt_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign mem_wr_en   = push;
    assign mem_wr_addr = wr_ptr_q;
    assign mem_wr_data = s_data;
    assign mem_rd_en   = fetch;
    assign mem_rd_addr = rd_ptr_q;
    assign m_valid     = m_valid_q;
    assign m_data      = mem_rd_data;
    assign count       = mem_cnt_q + CNTSIZE'(m_valid_q);

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    logic [CNTSIZE-1:0] count_d;
    logic               almost_full_q, almost_full_d;
    logic               almost_empty_q, almost_empty_d;

    // Flags are registered from the next-state count so they line up with
    // the count output in the same cycle.
    always_comb begin
        count_d        = mem_cnt_d + CNTSIZE'(m_valid_d);
        almost_full_d  = int'(count_d) >= AF_LEVEL;
        almost_empty_d = int'(count_d) <= AE_LEVEL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`else
    // Occupancy is reported through count only in this build.
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl
//
// Bench for fifo_ctrl with DEPTH=4, DATA_WIDTH=8 and a behavioural memory with
// a registered read port. Inputs change on the falling edge; outputs are
// sampled shortly after. Accepted writes are queued as expected data; words
// popped from the read side are queued as observed data and compared in
// order by each scenario task.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 2);

    logic          clk;
    logic          rst_n;
    logic          s_valid, s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid, m_ready;
    logic [DW-1:0] m_data;
    logic          mem_wr_en, mem_rd_en;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [DW-1:0] mem_wr_data, mem_rd_data;
    logic [CW-1:0] count;

    fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .count       (count)
    );

    // Behavioural simple dual-port memory with registered read data.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int            exp_wa   = 0;
    logic          last_push, last_pop;

    // One clock cycle: record handshakes, then move to the next falling edge.
    task automatic tick();
        #1;
        last_push = s_valid && s_ready;
        last_pop  = m_valid && m_ready;
        if (last_push) begin
            exp_q.push_back(s_data);
            exp_wa = (exp_wa + 1) % DEPTH;
        end
        if (last_pop) got_q.push_back(m_data);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0; rst_n = 1'b0;
        #2;
        n_checks++; if (s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b want 0", s_ready); else n_pass++;
        n_checks++; if (count !== '0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
        n_checks++; if ({mem_wr_en, mem_rd_en} !== 2'b00) $display("FAIL rst_mem_en: got %b want 00", {mem_wr_en, mem_rd_en}); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_wa = 0;
        tick();
        #1;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL idle_s_ready: got %b want 1", s_ready); else n_pass++;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL idle_m_valid: got %b want 0", m_valid); else n_pass++;
        n_checks++; if (count !== '0) $display("FAIL idle_count: got %0d want 0", count); else n_pass++;
        n_checks++; if ({mem_wr_en, mem_rd_en} !== 2'b00) $display("FAIL idle_mem_en: got %b want 00", {mem_wr_en, mem_rd_en}); else n_pass++;
    endtask

    task automatic test_single();
        s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b0;
        #1;
        n_checks++; if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, AW'(0), 8'hA5})
            $display("FAIL single_wr: got en=%b addr=%0d data=%h want 1/0/a5", mem_wr_en, mem_wr_addr, mem_wr_data); else n_pass++;
        tick();
        s_valid = 1'b0;
        #1;
        n_checks++; if ({mem_rd_en, mem_rd_addr} !== {1'b1, AW'(0)})
            $display("FAIL single_fetch: got en=%b addr=%0d want 1/0", mem_rd_en, mem_rd_addr); else n_pass++;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL single_latency: got m_valid=%b want 0", m_valid); else n_pass++;
        tick();
        #1;
        n_checks++; if ({m_valid, m_data} !== {1'b1, 8'hA5}) $display("FAIL single_out: got v=%b d=%h want 1/a5", m_valid, m_data); else n_pass++;
        n_checks++; if (count !== CW'(1)) $display("FAIL single_count: got %0d want 1", count); else n_pass++;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        #1;
        n_checks++; if ({m_valid, count} !== {1'b0, CW'(0)}) $display("FAIL single_empty: got v=%b cnt=%0d want 0/0", m_valid, count); else n_pass++;
        while (got_q.size() > 0) begin
            logic [DW-1:0] g, e;
            g = got_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++; if (g !== e) $display("FAIL single_data: got %h want %h", g, e); else n_pass++;
        end
    endtask

    task automatic test_fill();
        int n = 0;
        int gapless = 1;
        m_ready = 1'b0;
        for (int c = 0; c < 12 && n < 5; c++) begin
            s_valid = 1'b1; s_data = 8'h10 + DW'(n);
            tick();
            if (last_push) n++;
        end
        s_valid = 1'b1; s_data = 8'h15;
        #1;
        n_checks++; if (n !== 5) $display("FAIL fill_accepted: got %0d want 5", n); else n_pass++;
        n_checks++; if ({s_ready, count} !== {1'b0, CW'(5)}) $display("FAIL fill_full: got rdy=%b cnt=%0d want 0/5", s_ready, count); else n_pass++;
        repeat (3) tick();
        n_checks++; if (exp_q.size() !== 5) $display("FAIL fill_holdoff: got %0d queued want 5", exp_q.size()); else n_pass++;
        s_valid = 1'b0; m_ready = 1'b1;
        #1;
        // Full with a fetch this cycle: the freed slot is not offered yet.
        n_checks++; if (s_ready !== 1'b0) $display("FAIL fill_ready_lag: got %b want 0", s_ready); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (m_valid !== 1'b1) gapless = 0;
            tick();
        end
        n_checks++; if (gapless !== 1) $display("FAIL fill_gapless: got %0d want 1", gapless); else n_pass++;
        #1;
        n_checks++; if ({m_valid, count} !== {1'b0, CW'(0)}) $display("FAIL fill_drained: got v=%b cnt=%0d want 0/0", m_valid, count); else n_pass++;
        m_ready = 1'b0;
        while (got_q.size() > 0) begin
            logic [DW-1:0] g, e;
            g = got_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++; if (g !== e) $display("FAIL fill_data: got %h want %h", g, e); else n_pass++;
        end
        n_checks++; if (exp_q.size() !== 0) $display("FAIL fill_lost: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n_in = 0, pops = 0, first = -1, last = -1;
        m_ready = 1'b1;
        for (int c = 0; c < 40 && pops < 12; c++) begin
            s_valid = (n_in < 12); s_data = 8'h40 + DW'(n_in);
            #1;
            if (s_valid && s_ready) begin
                n_checks++; if (mem_wr_addr !== AW'(exp_wa)) $display("FAIL b2b_wr_addr: got %0d want %0d", mem_wr_addr, exp_wa); else n_pass++;
            end
            if (c >= 1 && c <= 12) begin
                n_checks++; if (count < CW'(1) || count > CW'(2)) $display("FAIL b2b_count: cycle %0d got %0d want 1..2", c, count); else n_pass++;
            end
            tick();
            if (last_push) n_in++;
            if (last_pop) begin
                pops++;
                if (first < 0) first = c;
                last = c;
            end
        end
        s_valid = 1'b0; m_ready = 1'b0;
        n_checks++; if (first !== 2) $display("FAIL b2b_fill_latency: got %0d want 2", first); else n_pass++;
        n_checks++; if ({pops, last} !== {32'd12, 32'd13}) $display("FAIL b2b_throughput: got pops=%0d last=%0d want 12/13", pops, last); else n_pass++;
        while (got_q.size() > 0) begin
            logic [DW-1:0] g, e;
            g = got_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++; if (g !== e) $display("FAIL b2b_data: got %h want %h", g, e); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int n_in = 0;
        logic [DW-1:0] held;
        for (int c = 0; c < 16; c++) begin
            s_valid = 1'b1; s_data = 8'h80 + DW'(n_in);
            m_ready = (c % 2 == 0);
            #1;
            if (m_valid && !m_ready) begin
                held = m_data;
                tick();
                n_checks++; if ({m_valid, m_data} !== {1'b1, held}) $display("FAIL bp_stable: got v=%b d=%h want 1/%h", m_valid, m_data, held); else n_pass++;
            end else begin
                tick();
            end
            if (last_push) n_in++;
        end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int c = 0; c < 20 && count != 0; c++) tick();
        m_ready = 1'b0;
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL bp_word_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        while (got_q.size() > 0) begin
            logic [DW-1:0] g, e;
            g = got_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            n_checks++; if (g !== e) $display("FAIL bp_data: got %h want %h", g, e); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int waited = 0;
        m_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            s_valid = 1'b1; s_data = 8'h60 + DW'(c);
            tick();
        end
        #1;
        n_checks++; if (count !== CW'(3)) $display("FAIL mid_count_before: got %0d want 3", count); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if ({m_valid, count, s_ready, mem_wr_en} !== {1'b0, CW'(0), 1'b0, 1'b0})
            $display("FAIL mid_async_reset: got v=%b cnt=%0d rdy=%b wr=%b want 0/0/0/0", m_valid, count, s_ready, mem_wr_en); else n_pass++;
        exp_q.delete(); got_q.delete(); exp_wa = 0;
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        s_valid = 1'b1; s_data = 8'h77; m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        while (got_q.size() == 0 && waited < 8) begin
            tick();
            waited++;
        end
        if (got_q.size() == 0) begin
            n_checks++;
            $display("FAIL mid_timeout: got no output in %0d cycles want 0x77", waited);
        end else begin
            logic [DW-1:0] g;
            g = got_q.pop_front();
            n_checks++; if (g !== 8'h77) $display("FAIL mid_first_word: got %h want 77", g); else n_pass++;
        end
        m_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
